// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - UART 8N1 receiver with FWFT receive FIFO; UART_RX_PARITY_EN adds an even parity bit (8E1)
module uart_rx_deser #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        uart_rx,
  input  logic        rx_en,
  input  logic [15:0] prescale,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [4:0]  fifo_level,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        parity_err,
  input  logic        err_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [2:0]  fill;
  logic [15:0] presc_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        push_vld;
  logic [7:0]  push_byte;
  logic        frame_evt;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
  logic        parity_evt;
`endif
  logic        tick, start_edge;

  // fill keeps edge detection off until rx_prev holds a real line sample, so a
  // line held low across reset release is not mistaken for a start bit
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 3'b000;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      fill    <= {fill[1:0], 1'b1};
    end
  end

  assign start_edge = fill[2] & rx_prev & ~rx_s2 & rx_en;
  assign tick       = (state != IDLE) && (presc_cnt == prescale);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      presc_cnt  <= 16'd0;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      push_vld   <= 1'b0;
      push_byte  <= 8'd0;
      frame_evt  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_evt <= 1'b0;
`endif
    end else begin
      push_vld  <= 1'b0;
      frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_evt <= 1'b0;
`endif
      if (state == IDLE || !rx_en || tick)
        presc_cnt <= 16'd0;
      else
        presc_cnt <= presc_cnt + 16'd1;

      if (!rx_en) begin
        state    <= IDLE;
        tick_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: if (start_edge) begin
            state    <= START;
            tick_cnt <= 4'd0;
          end
          START: if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_bad  <= 1'b0;
`endif
              state    <= rx_s2 ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          DATA: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift   <= {rx_s2, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_cnt == 3'd7) state <= PARITY;
`else
              if (bit_cnt == 3'd7) state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              if ((^shift) ^ rx_s2) begin
                par_bad    <= 1'b1;
                parity_evt <= 1'b1;
              end
              state <= STOP;
            end
          end
`endif
          STOP: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              if (rx_s2) begin
`ifdef UART_RX_PARITY_EN
                push_vld <= ~par_bad;
`else
                push_vld <= 1'b1;
`endif
                push_byte <= shift;
              end else begin
                frame_evt <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          full, pop, do_wr, overrun_evt;

  assign full        = (count == 5'(FIFO_DEPTH));
  assign pop         = rd_valid & rd_ready;
  assign do_wr       = push_vld & (~full | pop);
  assign overrun_evt = push_vld & full & ~pop;
  assign rd_valid    = (count != 5'd0);
  assign rd_data     = rd_valid ? mem[rd_ptr] : 8'd0;
  assign fifo_level  = count;

  always_ff @(posedge wb_clk_i) begin
    if (do_wr) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + 5'(do_wr) - 5'(pop);
    end
  end

  // an error event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= (frame_err & ~err_clr) | frame_evt;
      overrun_err <= (overrun_err & ~err_clr) | overrun_evt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) parity_err <= 1'b0;
    else          parity_err <= (parity_err & ~err_clr) | parity_evt;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port wb_clk_i  input  1  system clock, all logic on its rising edge.
REQ-003 The block SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port uart_rx  input  1  serial line, asynchronous to wb_clk_i, idle high.
REQ-005 The block SHALL have port rx_en  input  1  receiver enable.
REQ-006 The block SHALL have port prescale  input  16  oversample tick period minus one, in wb_clk_i cycles.
REQ-007 The block SHALL have port rd_data  output  8  FIFO head byte.
REQ-008 The block SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-009 The block SHALL have port rd_ready  input  1  consumer accepts head byte.
REQ-010 The block SHALL have port fifo_level  output  5  current FIFO occupancy.
REQ-011 The block SHALL have port frame_err  output  1  sticky framing error.
REQ-012 The block SHALL have port overrun_err  output  1  sticky overrun error.
REQ-013 The block SHALL have port parity_err  output  1  sticky parity error.
REQ-014 The block SHALL have port err_clr  input  1  clears all sticky errors.

Function
REQ-015 uart_rx SHALL pass a 2-flop synchronizer (reset value 1); all line decisions use the synchronized value.
REQ-016 An oversample tick SHALL pulse one cycle every prescale+1 cycles; prescale=0 ticks every cycle; the tick counter runs only while FSM is not IDLE and restarts at 0 on start detection.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on synchronized line 1->0 transition while rx_en=1; sample counter cleared.
REQ-019 START: at tick 7 line sampled; 0 -> DATA, 1 -> IDLE (glitch rejected, no error).
REQ-020 DATA: line sampled every 16 ticks from mid-bit, shifted in LSB first; after 8th bit -> PARITY if compiled in, else STOP.
REQ-021 STOP: mid-bit sample 1 -> push byte, IDLE; 0 -> frame_err set, byte discarded, IDLE; new start requires a fresh 1->0 transition.
REQ-022 FIFO SHALL be first-word fall-through: rd_valid=!empty, rd_data=head; pop when rd_valid&rd_ready.
REQ-023 Push while full without same-cycle pop SHALL drop the byte, set overrun_err, FIFO unchanged.
REQ-024 Push and pop in same cycle SHALL both occur (level unchanged, including at full).
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level counts 0..FIFO_DEPTH.
REQ-026 err_clr SHALL clear all sticky errors next cycle; an error event in the same cycle wins (flag stays 1).
REQ-027 rx_en=0 SHALL force FSM to IDLE next cycle, discarding any partial byte; FIFO contents and errors retained.

Reset
REQ-028 On wb_rst_i=1: FSM IDLE, counters 0, FIFO empty, rd_valid=0, rd_data=0, fifo_level=0, all error flags 0, synchronizer 1.
REQ-029 Reset mid-frame SHALL abort the frame; after release the receiver waits for a new 1->0 transition.

Configuration
REQ-030 With UART_RX_PARITY_EN defined: PARITY state samples a ninth bit mid-bit; even parity mismatch sets parity_err and discards the byte, then STOP proceeds normally.
REQ-031 Without UART_RX_PARITY_EN: no PARITY state, frame is 8N1, parity_err tied 0.

Verification
REQ-032 prescale=3, rx_en=1, send 0xA5 8N1 at 64 cycles/bit -> rd_valid=1, rd_data=0xA5, fifo_level=1 after stop mid-bit.
REQ-033 Low glitch of 20 cycles on idle line -> FSM returns IDLE, fifo_level=0, no error flags.
REQ-034 Frame 0x3C with stop bit 0 -> frame_err=1, fifo_level=0; err_clr pulse -> frame_err=0.
REQ-035 rd_ready=0, send 9 bytes 0x00..0x08 (FIFO_DEPTH=8) -> fifo_level=8, overrun_err=1, drains 0x00..0x07 in order.
REQ-036 wb_rst_i asserted during DATA bit 4, released, then send 0x5A -> exactly one byte 0x5A received.
REQ-037 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1, no push; with parity bit 1 -> 0x07 pushed.
